// File: rtl/control_unit_if.sv
// Datapath/memory-side signal bundle for the Mini-SRC control unit.
// With CU_INSTR_COUNT_EN defined it also carries the retired-instruction count.
interface control_unit_if;
    logic [31:0] in_ir;
    logic        in_mem_ready;
    logic        out_reg_clear;
    logic [3:0]  out_regfile_location;
    logic [3:0]  out_alu_opcode;
    logic        out_mdr_select;
    logic        out_inc_pc;
    logic        out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read;
    logic        out_pc_read, out_mdr_read;
    logic        out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write;
    logic        out_mdr_write, out_ir_write, out_y_write, out_mar_write;
    logic        out_mem_read, out_mem_write;
    logic        out_halted, out_illegal, out_mem_error;
`ifdef CU_INSTR_COUNT_EN
    logic [31:0] out_instr_count;
`endif

    modport master (
`ifdef CU_INSTR_COUNT_EN
        output out_instr_count,
`endif
        input  in_ir, in_mem_ready,
        output out_reg_clear, out_regfile_location, out_alu_opcode, out_mdr_select, out_inc_pc,
        output out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read,
        output out_pc_read, out_mdr_read,
        output out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write,
        output out_mdr_write, out_ir_write, out_y_write, out_mar_write,
        output out_mem_read, out_mem_write, out_halted, out_illegal, out_mem_error
    );

    modport slave (
`ifdef CU_INSTR_COUNT_EN
        input  out_instr_count,
`endif
        output in_ir, in_mem_ready,
        input  out_reg_clear, out_regfile_location, out_alu_opcode, out_mdr_select, out_inc_pc,
        input  out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read,
        input  out_pc_read, out_mdr_read,
        input  out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write,
        input  out_mdr_write, out_ir_write, out_y_write, out_mar_write,
        input  out_mem_read, out_mem_write, out_halted, out_illegal, out_mem_error
    );
endinterface

// File: rtl/control_unit.sv
// Mini-SRC hardwired sequencer: fetch, decode and execute strobes for the single-bus datapath.
// Optional macro CU_INSTR_COUNT_EN adds the retired-instruction counter out_instr_count.
module control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic            clk,
    input logic            in_clr,
    control_unit_if.master bus
);
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [3:0] {RST, F0, F1, F2, DEC, E1, E2, E3, E4, HALT} state_t;
    typedef enum logic [3:0] {C_LD, C_ST, C_MFHI, C_MFLO, C_NOP, C_ALU, C_MULDIV, C_HALT, C_ILL} op_class_t;

    typedef struct packed {
        logic       reg_clear;
        logic [3:0] location;
        logic [3:0] alu_opcode;
        logic       inc_pc;
        logic       regfile_read, hi_read, lo_read, z_hi_read, z_lo_read, pc_read, mdr_read;
        logic       regfile_write, hi_write, lo_write, z_write, pc_write, mdr_write;
        logic       ir_write, y_write, mar_write;
        logic       mem_read, mem_write, halted;
        logic       rd_wait;
    } strobe_t;

    state_t          state, nxt;
    strobe_t         strb;
    op_class_t       cls;
    logic [CNT_W-1:0] wait_cnt;
    logic            mem_error;
    logic            mem_state, timeout, retire;
    logic [4:0]      op;
    logic [3:0]      ra, rb, rc;
    logic            unused_ir;

    assign op        = bus.in_ir[31:27];
    assign ra        = bus.in_ir[26:23];
    assign rb        = bus.in_ir[22:19];
    assign rc        = bus.in_ir[18:15];
    assign unused_ir = ^bus.in_ir[14:0];

    function automatic op_class_t op_class(input logic [4:0] o);
        op_class_t c;
        c = C_ILL;
        case (o)
            5'h00: c = C_LD;
            5'h01: c = C_ST;
            5'h02: c = C_MFHI;
            5'h03: c = C_MFLO;
            5'h04: c = C_NOP;
            5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15,
            5'h16, 5'h17, 5'h18, 5'h19, 5'h1A, 5'h1B: c = C_ALU;
            5'h1C, 5'h1D: c = C_MULDIV;
            5'h1F: c = C_HALT;
            default: c = C_ILL;
        endcase
        return c;
    endfunction

    // Strobe pattern for a state; registered one cycle ahead so outputs line up with the state.
    function automatic strobe_t decode(input state_t s, input op_class_t c, input logic [3:0] alu,
                                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] r);
        strobe_t d;
        d = '0;
        case (s)
            RST: d.reg_clear = 1'b1;
            F0: begin d.pc_read = 1'b1; d.mar_write = 1'b1; d.pc_write = 1'b1; d.inc_pc = 1'b1; end
            F1: begin d.mem_read = 1'b1; d.rd_wait = 1'b1; end
            F2: begin d.mdr_read = 1'b1; d.ir_write = 1'b1; end
            E1: case (c)
                C_LD, C_ST:      begin d.location = b; d.regfile_read = 1'b1; d.mar_write = 1'b1; end
                C_MFHI:          begin d.hi_read = 1'b1; d.location = a; d.regfile_write = 1'b1; end
                C_MFLO:          begin d.lo_read = 1'b1; d.location = a; d.regfile_write = 1'b1; end
                C_ALU, C_MULDIV: begin d.location = b; d.regfile_read = 1'b1; d.y_write = 1'b1; end
                default: ;
            endcase
            E2: case (c)
                C_LD:            begin d.mem_read = 1'b1; d.rd_wait = 1'b1; end
                C_ST:            begin d.location = a; d.regfile_read = 1'b1; d.mdr_write = 1'b1; end
                C_ALU, C_MULDIV: begin
                    d.location = r; d.regfile_read = 1'b1; d.alu_opcode = alu; d.z_write = 1'b1;
                end
                default: ;
            endcase
            E3: case (c)
                C_LD:     begin d.mdr_read = 1'b1; d.location = a; d.regfile_write = 1'b1; end
                C_ST:     d.mem_write = 1'b1;
                C_ALU:    begin d.z_lo_read = 1'b1; d.location = a; d.regfile_write = 1'b1; end
                C_MULDIV: begin d.z_lo_read = 1'b1; d.lo_write = 1'b1; end
                default: ;
            endcase
            E4: if (c == C_MULDIV) begin d.z_hi_read = 1'b1; d.hi_write = 1'b1; end
            HALT: d.halted = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

    // Registered mem strobes mark the memory-wait states.
    always_comb begin
        cls       = op_class(op);
        mem_state = strb.mem_read | strb.mem_write;
        timeout   = (MEM_TIMEOUT != 0) && mem_state && !bus.in_mem_ready &&
                    (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
        nxt       = state;
        case (state)
            RST: nxt = F0;
            F0:  nxt = F1;
            F1:  if (bus.in_mem_ready) nxt = F2; else if (timeout) nxt = HALT;
            F2:  nxt = DEC;
            DEC: case (cls)
                C_NOP, C_ILL: nxt = F0;
                C_HALT:       nxt = HALT;
                default:      nxt = E1;
            endcase
            E1:  nxt = (cls == C_MFHI || cls == C_MFLO) ? F0 : E2;
            E2:  if (cls != C_LD || bus.in_mem_ready) nxt = E3; else if (timeout) nxt = HALT;
            E3:  begin
                if (cls == C_MULDIV) nxt = E4;
                else if (cls != C_ST || bus.in_mem_ready) nxt = F0;
                else if (timeout) nxt = HALT;
            end
            E4:   nxt = F0;
            HALT: nxt = HALT;
            default: nxt = RST;
        endcase
        retire = (nxt == F0) && (state inside {DEC, E1, E2, E3, E4});
    end

`ifdef CU_INSTR_COUNT_EN
    logic [31:0] instr_count;
    assign bus.out_instr_count = instr_count;
`endif

    always_ff @(posedge clk) begin
        if (in_clr) begin
            state     <= RST;
            strb      <= decode(RST, C_NOP, 4'd0, 4'd0, 4'd0, 4'd0);
            wait_cnt  <= '0;
            mem_error <= 1'b0;
`ifdef CU_INSTR_COUNT_EN
            instr_count <= '0;
`endif
        end else begin
            state    <= nxt;
            strb     <= decode(nxt, cls, op[3:0], ra, rb, rc);
            wait_cnt <= (mem_state && !bus.in_mem_ready && !timeout) ? wait_cnt + CNT_W'(1) : '0;
            if (timeout) mem_error <= 1'b1;
`ifdef CU_INSTR_COUNT_EN
            if (state == RST) instr_count <= '0;
            else if (retire)  instr_count <= instr_count + 32'd1;
`endif
        end
    end

    assign bus.out_reg_clear        = strb.reg_clear;
    assign bus.out_regfile_location = strb.location;
    assign bus.out_alu_opcode       = strb.alu_opcode;
    assign bus.out_inc_pc           = strb.inc_pc;
    assign bus.out_regfile_read     = strb.regfile_read;
    assign bus.out_hi_read          = strb.hi_read;
    assign bus.out_lo_read          = strb.lo_read;
    assign bus.out_z_hi_read        = strb.z_hi_read;
    assign bus.out_z_lo_read        = strb.z_lo_read;
    assign bus.out_pc_read          = strb.pc_read;
    assign bus.out_mdr_read         = strb.mdr_read;
    assign bus.out_regfile_write    = strb.regfile_write;
    assign bus.out_hi_write         = strb.hi_write;
    assign bus.out_lo_write         = strb.lo_write;
    assign bus.out_z_write          = strb.z_write;
    assign bus.out_pc_write         = strb.pc_write;
    assign bus.out_ir_write         = strb.ir_write;
    assign bus.out_y_write          = strb.y_write;
    assign bus.out_mar_write        = strb.mar_write;
    assign bus.out_mem_read         = strb.mem_read;
    assign bus.out_mem_write        = strb.mem_write;
    assign bus.out_halted           = strb.halted;
    assign bus.out_mem_error        = mem_error;
    // Read data is captured in the same cycle memory reports ready.
    assign bus.out_mdr_select       = strb.rd_wait & bus.in_mem_ready;
    assign bus.out_mdr_write        = strb.mdr_write | (strb.rd_wait & bus.in_mem_ready);
    assign bus.out_illegal          = (state == DEC) && (cls == C_ILL);
    // retire only feeds the optional counter.
    logic unused_retire;
    assign unused_retire = retire;
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed per-cycle expected strobe vectors, checked by a monitor.
module tb_control_unit;
    typedef struct packed {
        logic       reg_clear;
        logic [3:0] loc;
        logic [3:0] alu;
        logic       mdr_sel, inc_pc;
        logic       rf_rd, hi_rd, lo_rd, zh_rd, zl_rd, pc_rd, mdr_rd;
        logic       rf_wr, hi_wr, lo_wr, z_wr, pc_wr, mdr_wr, ir_wr, y_wr, mar_wr;
        logic       mem_rd, mem_wr, halted, illegal, mem_error;
    } obs_t;

    logic        clk = 1'b0;
    logic        clr, rdy, clr_t, rdy_t;
    logic [31:0] ir;
    obs_t        obs_m, obs_t2;
    obs_t        exp_q[$];
    string       nm_q[$];
    bit          sel_q[$];
    int          checks = 0;
    int          errors = 0;

    control_unit_if mif();
    control_unit_if tif();

    assign mif.in_ir        = ir;
    assign mif.in_mem_ready = rdy;
    assign tif.in_ir        = 32'h0;
    assign tif.in_mem_ready = rdy_t;

    control_unit #(.MEM_TIMEOUT(16)) dut   (.clk(clk), .in_clr(clr),   .bus(mif));
    control_unit #(.MEM_TIMEOUT(4))  dut_t (.clk(clk), .in_clr(clr_t), .bus(tif));

    always #5 clk = ~clk;

    assign obs_m = {mif.out_reg_clear, mif.out_regfile_location, mif.out_alu_opcode,
                    mif.out_mdr_select, mif.out_inc_pc,
                    mif.out_regfile_read, mif.out_hi_read, mif.out_lo_read, mif.out_z_hi_read,
                    mif.out_z_lo_read, mif.out_pc_read, mif.out_mdr_read,
                    mif.out_regfile_write, mif.out_hi_write, mif.out_lo_write, mif.out_z_write,
                    mif.out_pc_write, mif.out_mdr_write, mif.out_ir_write, mif.out_y_write,
                    mif.out_mar_write, mif.out_mem_read, mif.out_mem_write,
                    mif.out_halted, mif.out_illegal, mif.out_mem_error};
    assign obs_t2 = {tif.out_reg_clear, tif.out_regfile_location, tif.out_alu_opcode,
                    tif.out_mdr_select, tif.out_inc_pc,
                    tif.out_regfile_read, tif.out_hi_read, tif.out_lo_read, tif.out_z_hi_read,
                    tif.out_z_lo_read, tif.out_pc_read, tif.out_mdr_read,
                    tif.out_regfile_write, tif.out_hi_write, tif.out_lo_write, tif.out_z_write,
                    tif.out_pc_write, tif.out_mdr_write, tif.out_ir_write, tif.out_y_write,
                    tif.out_mar_write, tif.out_mem_read, tif.out_mem_write,
                    tif.out_halted, tif.out_illegal, tif.out_mem_error};

    // Monitor: one expected vector per pushed cycle, compared mid-cycle.
    initial begin
        obs_t  e, a;
        string n;
        bit    s;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                s = sel_q.pop_front();
                a = s ? obs_t2 : obs_m;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", n, a, e);
                end
            end
        end
    end

    function automatic obs_t e_rst();
        obs_t e = '0;
        e.reg_clear = 1'b1;
        return e;
    endfunction

    function automatic obs_t e_f0();
        obs_t e = '0;
        e.pc_rd = 1'b1; e.mar_wr = 1'b1; e.pc_wr = 1'b1; e.inc_pc = 1'b1;
        return e;
    endfunction

    function automatic obs_t e_memrd(input logic ready);
        obs_t e = '0;
        e.mem_rd = 1'b1; e.mdr_sel = ready; e.mdr_wr = ready;
        return e;
    endfunction

    task automatic step(input bit sel, input logic r, input logic c, input obs_t e, input string n);
        if (sel) begin rdy_t = r; clr_t = c; end
        else     begin rdy = r;   clr = c;   end
        exp_q.push_back(e);
        nm_q.push_back(n);
        sel_q.push_back(sel);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] v, input logic ill, input string tag);
        obs_t e;
        ir = v;
        step(1'b0, 1'b1, 1'b0, e_f0(), {tag, "_f0"});
        step(1'b0, 1'b1, 1'b0, e_memrd(1'b1), {tag, "_f1"});
        e = '0; e.mdr_rd = 1'b1; e.ir_wr = 1'b1;
        step(1'b0, 1'b1, 1'b0, e, {tag, "_f2"});
        e = '0; e.illegal = ill;
        step(1'b0, 1'b1, 1'b0, e, {tag, "_dec"});
    endtask

    initial begin
        obs_t e;
        clr = 1'b1; rdy = 1'b0; ir = 32'h8088_8000;
        clr_t = 1'b1; rdy_t = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // Reset taken in the middle of a fetch memory wait
        step(1'b0, 1'b0, 1'b1, e_memrd(1'b0), "pre_clr_f1");
        step(1'b0, 1'b0, 1'b1, e_rst(), "clr_cycle1");
        step(1'b0, 1'b0, 1'b0, e_rst(), "clr_cycle2");

        // ADD r1,r1,r1
        fetch(32'h8088_8000, 1'b0, "add");
        e = '0; e.loc = 4'd1; e.rf_rd = 1'b1; e.y_wr = 1'b1;               step(1'b0, 1'b1, 1'b0, e, "add_e1");
        e = '0; e.loc = 4'd1; e.rf_rd = 1'b1; e.alu = 4'd0; e.z_wr = 1'b1; step(1'b0, 1'b1, 1'b0, e, "add_e2");
        e = '0; e.zl_rd = 1'b1; e.loc = 4'd1; e.rf_wr = 1'b1;              step(1'b0, 1'b1, 1'b0, e, "add_e3");

        // LD r5,(r2) with three wait cycles
        fetch(32'h0290_0000, 1'b0, "ld");
        e = '0; e.loc = 4'd2; e.rf_rd = 1'b1; e.mar_wr = 1'b1;             step(1'b0, 1'b1, 1'b0, e, "ld_e1");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, e_memrd(1'b0), $sformatf("ld_e2_wait%0d", i));
        step(1'b0, 1'b1, 1'b0, e_memrd(1'b1), "ld_e2_ready");
        e = '0; e.mdr_rd = 1'b1; e.loc = 4'd5; e.rf_wr = 1'b1;             step(1'b0, 1'b1, 1'b0, e, "ld_e3");

        // ST (r4),r3 with one write wait
        fetch(32'h09A0_0000, 1'b0, "st");
        e = '0; e.loc = 4'd4; e.rf_rd = 1'b1; e.mar_wr = 1'b1;             step(1'b0, 1'b1, 1'b0, e, "st_e1");
        e = '0; e.loc = 4'd3; e.rf_rd = 1'b1; e.mdr_wr = 1'b1;             step(1'b0, 1'b1, 1'b0, e, "st_e2");
        e = '0; e.mem_wr = 1'b1;
        step(1'b0, 1'b0, 1'b0, e, "st_e3_wait");
        step(1'b0, 1'b1, 1'b0, e, "st_e3_ready");

        // MUL r6,r7
        fetch(32'hE033_8000, 1'b0, "mul");
        e = '0; e.loc = 4'd6; e.rf_rd = 1'b1; e.y_wr = 1'b1;                step(1'b0, 1'b1, 1'b0, e, "mul_e1");
        e = '0; e.loc = 4'd7; e.rf_rd = 1'b1; e.alu = 4'hC; e.z_wr = 1'b1;  step(1'b0, 1'b1, 1'b0, e, "mul_e2");
        e = '0; e.zl_rd = 1'b1; e.lo_wr = 1'b1;                             step(1'b0, 1'b1, 1'b0, e, "mul_e3");
        e = '0; e.zh_rd = 1'b1; e.hi_wr = 1'b1;                             step(1'b0, 1'b1, 1'b0, e, "mul_e4");

        // MFHI r9, NOP, illegal 0x07
        fetch(32'h1480_0000, 1'b0, "mfhi");
        e = '0; e.hi_rd = 1'b1; e.loc = 4'd9; e.rf_wr = 1'b1;              step(1'b0, 1'b1, 1'b0, e, "mfhi_e1");
        fetch(32'h2000_0000, 1'b0, "nop");
        fetch(32'h3800_0000, 1'b1, "ill");

        // HALT: stays put with memory ready toggling, until cleared
        fetch(32'hF800_0000, 1'b0, "halt");
        e = '0; e.halted = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'(i % 2), 1'b0, e, $sformatf("halted%0d", i));
        step(1'b0, 1'b0, 1'b1, e, "halt_clr");
        step(1'b0, 1'b0, 1'b0, e_rst(), "halt_rst");
        ir = 32'h2000_0000;
        step(1'b0, 1'b1, 1'b0, e_f0(), "halt_resume_f0");

        // Memory timeout on the MEM_TIMEOUT=4 instance
        step(1'b1, 1'b0, 1'b1, e_rst(), "to_rst_a");
        step(1'b1, 1'b0, 1'b0, e_rst(), "to_rst_b");
        step(1'b1, 1'b0, 1'b0, e_f0(), "to_f0");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, e_memrd(1'b0), $sformatf("to_f1_wait%0d", i));
        e = '0; e.halted = 1'b1; e.mem_error = 1'b1;
        step(1'b1, 1'b0, 1'b0, e, "to_halt_err");
        step(1'b1, 1'b1, 1'b0, e, "to_halt_ready_ignored");
        step(1'b1, 1'b0, 1'b1, e, "to_halt_clr");
        step(1'b1, 1'b0, 1'b0, e_rst(), "to_err_cleared");

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired sequencer for the Mini-SRC single-bus datapath.
- Drives every datapath read/write strobe, the register-file select, the ALU opcode, the MDR source select and the PC-increment control.
- Runs fetch (PC→MAR, memory→MDR, MDR→IR), decodes the IR value fed back to it, then executes one instruction class before returning to fetch.
- Handshakes with an external memory model through mem_read/mem_write and mem_ready.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait on in_mem_ready before flagging out_mem_error (0 disables the timeout).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- in_clr  input  1  reset: one clock, synchronous, active-high
- in_ir  input  32  current IR contents; op=[31:27], ra=[26:23], rb=[22:19], rc=[18:15]
- in_mem_ready  input  1  memory completes current read/write this cycle
- out_reg_clear  output  1  to datapath in_reg_clear
- out_regfile_location  output  4  register-file select
- out_alu_opcode  output  4  ALU opcode
- out_mdr_select  output  1  0 = bus, 1 = memory
- out_inc_pc  output  1  PC loads PC+1 instead of bus
- out_regfile_read, out_hi_read, out_lo_read, out_z_hi_read, out_z_lo_read, out_pc_read, out_mdr_read  output  1 each  bus drivers
- out_regfile_write, out_hi_write, out_lo_write, out_z_write, out_pc_write, out_mdr_write, out_ir_write, out_y_write, out_mar_write  output  1 each  register loads
- out_mem_read, out_mem_write  output  1 each  memory request, level, held until in_mem_ready
- out_halted  output  1  core stopped
- out_illegal  output  1  one-cycle pulse on undefined opcode
- out_mem_error  output  1  sticky memory-timeout flag

Behaviour:
- States: RST, F0, F1, F2, DEC, E1, E2, E3, E4, HALT. Outputs are decoded from state, except strobes qualified by in_mem_ready.
- in_clr=1: next state RST, out_mem_error←0, wait counter←0. In RST, out_reg_clear=1 and every other output 0. RST→F0 unconditionally. in_clr overrides any state, including mid-memory-wait.
- At most one *_read bus driver is high in any cycle. All outputs not listed for a state are 0, and out_regfile_location is 0 when unused.
- F0: pc_read, mar_write, pc_write, inc_pc. → F1.
- F1: mem_read=1. When in_mem_ready: mdr_select=1, mdr_write=1, → F2; otherwise stay in F1.
- F2: mdr_read, ir_write. → DEC.
- DEC: no strobes, IR now valid. Branch on op:
  - 0x00 LD ra,(rb): E1 location=rb, regfile_read, mar_write. E2 mem_read, wait as in F1, mdr_select=1 and mdr_write on ready. E3 mdr_read, location=ra, regfile_write. → F0.
  - 0x01 ST (rb),ra: E1 rb→MAR. E2 location=ra, regfile_read, mdr_select=0, mdr_write. E3 mem_write held until ready. → F0.
  - 0x02 MFHI ra: E1 hi_read, location=ra, regfile_write. 0x03 MFLO ra: same with lo_read. → F0.
  - 0x04 NOP: → F0.
  - 0x10–0x1B ALU ra,rb,rc: E1 location=rb, regfile_read, y_write. E2 location=rc, regfile_read, alu_opcode=op[3:0], z_write. E3 z_lo_read, location=ra, regfile_write. → F0.
  - 0x1C MUL / 0x1D DIV rb,rc: E1 and E2 as ALU class. E3 z_lo_read, lo_write. E4 z_hi_read, hi_write. → F0.
  - 0x1F HALT: → HALT, out_halted=1, stay until in_clr.
  - Any other op: out_illegal=1 for the DEC cycle, treated as NOP, → F0.
- out_alu_opcode=op[3:0] in E2 of the ALU, MUL and DIV classes; 0 otherwise.
- Zero-wait latency in cycles, counted from F0 to the next F0: ALU 7, LD 7, ST 7, MFHI 5, NOP 4, MUL/DIV 8. Each extra wait cycle adds 1.
- Memory wait: the counter increments each non-ready cycle in a mem state and clears on leaving it. If it reaches MEM_TIMEOUT: out_mem_error←1, request dropped, → HALT.
- in_mem_ready outside a memory state is ignored.

Optional Feature:
- Macro CU_INSTR_COUNT_EN.
- Defined: adds output out_instr_count [31:0], cleared in RST. It increments by 1 on every transition into F0 from an execute or DEC state (retired instruction, including NOP and illegal), wraps 0xFFFFFFFF→0, and does not count HALT.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset: hold in_clr 2 cycles from arbitrary state → out_reg_clear=1 in both cycles, all strobes 0; F0 strobes (pc_read, mar_write, pc_write, inc_pc) on the cycle after release.
- ADD: in_ir=0x8088_8000 (op 0x10, ra=1, rb=1, rc=1), ready always 1 → strobes match F0,F1,F2,DEC,E1,E2,E3 exactly. E2: alu_opcode=0, location=1. Next F0 at cycle 7.
- LD with wait: op 0x00, rb=2, ra=5, ready low 3 cycles in E2 → mem_read held 4 cycles, mdr_write only on ready cycle, E3 writes location=5; total 10 cycles.
- MUL: op 0x1C → E3 asserts z_lo_read+lo_write, E4 asserts z_hi_read+hi_write, never regfile_write.
- Illegal/HALT: op 0x07 → out_illegal high exactly one cycle, fetch resumes. Then op 0x1F → out_halted=1 and no strobes for 20 cycles, until in_clr.
- Timeout: MEM_TIMEOUT=4, ready never high in F1 → out_mem_error=1 after 4 cycles, HALT entered, cleared by in_clr.
